boot_image_loader: RTL and testbench

Synthesisable program loader that fills a memory image from a byte stream while holding the 6502 core in reset. It then sets the core's reset vector and releases the core.
Sits between the CPU memory port and a single-port RAM (generic_ram) and muxes the RAM port between loader and CPU.
Generalises the bench-only load sequence: any number of address/length blocks, parametrised address width and memory depth, bounds checking, and a handshaked input.

---
 rtl/boot_image_loader_if.sv | 29 ++
 rtl/boot_image_loader.sv | 250 +++++++++++++++++++++++++
 tb/tb_boot_image_loader.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_image_loader_if.sv
// Stream, CPU-side and RAM-side signals of the boot image loader.
//   in_data/in_valid/in_ready : byte stream with valid/ready handshake
//   cpu_addr/cpu_wdata/cpu_we : memory port driven by the 6502 core
//   mem_addr/mem_wdata/mem_we : muxed port towards the single-port RAM
// master: the environment (stream source, CPU, RAM); slave: the loader.
`timescale 1ns/1ps
interface boot_image_loader_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;

  modport master (
    output in_data, in_valid, cpu_addr, cpu_wdata, cpu_we,
    input  in_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  in_data, in_valid, cpu_addr, cpu_wdata, cpu_we,
    output in_ready, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/boot_image_loader.sv
// Boot image loader: holds the CPU in reset, fills RAM from a byte stream of
// BLOCK (0x01 addr len data...) and END (0x02 vector) records, then loads the
// reset vector and releases the CPU.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse starting a load (ignored while busy)
//   bus        : stream handshake, CPU port in, RAM port out (slave modport)
//   cpu_run    : 1 = CPU out of reset; also selects CPU as RAM port owner
//   pc_reset   : CPU reset vector
//   busy/done/err : load status
// Optional feature macro CHECKSUM_EN: END is followed by a checksum byte and
// the mod-256 sum of all accepted bytes must be zero.
`timescale 1ns/1ps
module boot_image_loader #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       MEM_DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] DEFAULT_VEC = ADDR_W'(16'h0200)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  boot_image_loader_if.slave    bus,
  output logic                  cpu_run,
  output logic [ADDR_W-1:0]     pc_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned       NB       = ADDR_W / 8;
  localparam logic [7:0]        LastLane = 8'(NB - 1);
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(MEM_DEPTH);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StHdr  = 3'd1;
  localparam logic [2:0] StAddr = 3'd2;
  localparam logic [2:0] StLen  = 3'd3;
  localparam logic [2:0] StData = 3'd4;
  localparam logic [2:0] StVec  = 3'd5;
  localparam logic [2:0] StDone = 3'd6;
  localparam logic [2:0] StErr  = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] field_q, field_d, field_nx;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [7:0]        sum_q, sum_d, sum_nx;
  logic              ld_we_q, ld_we_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [7:0]        ld_wdata_q, ld_wdata_d;
  logic              run_q, run_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  logic [ADDR_W:0]   blk_end;
  logic              out_of_range;

  assign bus.in_ready = (state_q == StHdr) || (state_q == StAddr) || (state_q == StLen) ||
                        (state_q == StData) || (state_q == StVec);
  assign accept       = bus.in_valid && bus.in_ready;

  // CPU owns the RAM port once released; before that CPU writes are dropped.
  assign bus.mem_addr  = run_q ? bus.cpu_addr  : ld_addr_q;
  assign bus.mem_wdata = run_q ? bus.cpu_wdata : ld_wdata_q;
  assign bus.mem_we    = run_q ? bus.cpu_we    : ld_we_q;

  assign cpu_run  = run_q;
  assign pc_reset = pc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

  assign sum_nx = sum_q + bus.in_data;

  // Multi-byte field with the current little-endian lane replaced by in_data.
  always_comb begin
    field_nx = field_q;
    for (int unsigned b = 0; b < NB; b++) begin
      if (cnt_q == 8'(b)) field_nx[b*8 +: 8] = bus.in_data;
    end
  end

  // Bounds check at ADDR_W+1 bits; evaluated with the just-completed length.
  assign blk_end      = {1'b0, addr_q} + {1'b0, field_nx};
  assign out_of_range = ({1'b0, addr_q} >= DepthW) ||
                        ((field_nx != '0) && (blk_end > DepthW));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    field_d    = field_q;
    addr_d     = addr_q;
    len_d      = len_q;
    sum_d      = sum_q;
    ld_we_d    = 1'b0;
    ld_addr_d  = ld_addr_q;
    ld_wdata_d = ld_wdata_q;
    run_d      = run_q;
    pc_d       = pc_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StHdr;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          run_d   = 1'b0;
          sum_d   = 8'h00;
          cnt_d   = '0;
        end else if (state_q == StDone) begin
          // Release lags DONE entry by one cycle.
          run_d = 1'b1;
        end
      end
      StHdr: begin
        if (accept) begin
          sum_d = sum_nx;
          cnt_d = '0;
          if (bus.in_data == 8'h01) begin
            state_d = StAddr;
          end else if (bus.in_data == 8'h02) begin
            state_d = StVec;
          end else begin
            state_d = StErr;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      StAddr: begin
        if (accept) begin
          sum_d   = sum_nx;
          field_d = field_nx;
          if (cnt_q == LastLane) begin
            addr_d  = field_nx;
            cnt_d   = '0;
            state_d = StLen;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StLen: begin
        if (accept) begin
          sum_d   = sum_nx;
          field_d = field_nx;
          if (cnt_q == LastLane) begin
            len_d = field_nx;
            cnt_d = '0;
            if (out_of_range) begin
              state_d = StErr;
              busy_d  = 1'b0;
              err_d   = 1'b1;
            end else if (field_nx == '0) begin
              state_d = StHdr;
            end else begin
              state_d = StData;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StData: begin
        if (accept) begin
          sum_d      = sum_nx;
          ld_we_d    = 1'b1;
          ld_addr_d  = addr_q;
          ld_wdata_d = bus.in_data;
          addr_d     = addr_q + ADDR_W'(1);
          len_d      = len_q - ADDR_W'(1);
          if (len_q == ADDR_W'(1)) state_d = StHdr;
        end
      end
      StVec: begin
        if (accept) begin
          sum_d = sum_nx;
`ifdef CHECKSUM_EN
          if (cnt_q < 8'(NB)) begin
            field_d = field_nx;
            cnt_d   = cnt_q + 8'd1;
          end else if (sum_nx == 8'h00) begin
            pc_d    = field_q;
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StErr;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end
`else
          field_d = field_nx;
          if (cnt_q == LastLane) begin
            pc_d    = field_nx;
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      field_q    <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      sum_q      <= 8'h00;
      ld_we_q    <= 1'b0;
      ld_addr_q  <= '0;
      ld_wdata_q <= 8'h00;
      run_q      <= 1'b0;
      pc_q       <= DEFAULT_VEC;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      field_q    <= field_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      ld_we_q    <= ld_we_d;
      ld_addr_q  <= ld_addr_d;
      ld_wdata_q <= ld_wdata_d;
      run_q      <= run_d;
      pc_q       <= pc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_boot_image_loader.sv
`timescale 1ns/1ps
module tb_boot_image_loader;

  localparam int MEM_DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cpu_run;
  logic [15:0] pc_reset;
  logic        busy;
  logic        done;
  logic        err;

  boot_image_loader_if #(.ADDR_W(16)) bus ();

  boot_image_loader #(
    .ADDR_W     (16),
    .MEM_DEPTH  (MEM_DEPTH),
    .DEFAULT_VEC(16'h0200)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_run (cpu_run),
    .pc_reset(pc_reset),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stream under test and what the model derives from it.
  logic [7:0]  strm[$];
  bit          exp_is_data[64];
  logic [15:0] exp_addr[64];
  logic [7:0]  exp_data[64];
  int          stop_n;
  bit          exp_done;
  logic [15:0] exp_pc;

  int          cur_idx = -1;
  int          pend    = -1;
  int          wr_seen = 0;
  bit          chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Parse the stream by its record rules: which byte indices are data bytes and
  // where they land, where the loader stops consuming, and the final outcome.
  task automatic model_parse();
    int i;
    int addr;
    int len;
    int vec;
    for (int j = 0; j < 64; j++) exp_is_data[j] = 1'b0;
    i        = 0;
    exp_done = 1'b0;
    stop_n   = strm.size();
    while (i < strm.size()) begin
      if (strm[i] == 8'h01) begin
        addr = int'(strm[i+1]) + 256 * int'(strm[i+2]);
        len  = int'(strm[i+3]) + 256 * int'(strm[i+4]);
        i += 5;
        if (addr >= MEM_DEPTH || (len != 0 && addr + len > MEM_DEPTH)) begin
          stop_n = i;
          return;
        end
        for (int k = 0; k < len; k++) begin
          exp_is_data[i] = 1'b1;
          exp_addr[i]    = 16'(addr + k);
          exp_data[i]    = strm[i];
          i++;
        end
      end else if (strm[i] == 8'h02) begin
        vec = int'(strm[i+1]) + 256 * int'(strm[i+2]);
        i += 3;
`ifdef CHECKSUM_EN
        begin
          int s = 0;
          for (int j = 0; j <= i; j++) s += int'(strm[j]);
          i += 1;
          stop_n = i;
          if (s % 256 == 0) begin
            exp_done = 1'b1;
            exp_pc   = 16'(vec);
          end
        end
`else
        stop_n   = i;
        exp_done = 1'b1;
        exp_pc   = 16'(vec);
`endif
        return;
      end else begin
        stop_n = i + 1;
        return;
      end
    end
  endtask

  task automatic add_cs(input logic [7:0] delta);
`ifdef CHECKSUM_EN
    logic [7:0] s = 8'h00;
    foreach (strm[j]) s += strm[j];
    strm.push_back(8'h00 - s + delta);
`else
    if (delta != 8'h00) $display("note: checksum delta unused in this build");
`endif
  endtask

  // Drives start then stream bytes up to the model's stop point. Inputs change
  // 1ns after the rising edge. rst_idx >= 0 asserts rst together with that byte.
  task automatic send_stream(input int rst_idx, input int max_gap);
    int g;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < stop_n; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (g) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = strm[i];
      cur_idx      = i;
      if (i == rst_idx) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      chk($sformatf("in_ready_byte%0d", i), {31'd0, bus.in_ready}, 32'd1);
      if (!bus.in_ready) break;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    cur_idx      = -1;
  endtask

  task automatic finish_check(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, done}, {31'd0, exp_done});
    chk({nm, "_err"}, {31'd0, err}, {31'd0, !exp_done});
    chk({nm, "_pc"}, {16'd0, pc_reset}, {16'd0, exp_pc});
    chk({nm, "_run_early"}, {31'd0, cpu_run}, 32'd0);
    chk({nm, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk({nm, "_run"}, {31'd0, cpu_run}, {31'd0, exp_done});
  endtask

  // Per-cycle check of the RAM port: the cycle after a data byte is accepted it
  // must carry that byte's write, otherwise the loader must not write.
  always begin
    @(negedge clk);
    if (chk_en) begin
      if (cpu_run) begin
        chk("mux_addr", {16'd0, bus.mem_addr}, {16'd0, bus.cpu_addr});
        chk("mux_wdata", {24'd0, bus.mem_wdata}, {24'd0, bus.cpu_wdata});
        chk("mux_we", {31'd0, bus.mem_we}, {31'd0, bus.cpu_we});
      end else begin
        if (bus.mem_we) wr_seen++;
        if (pend >= 0 && exp_is_data[pend]) begin
          chk("wr_we", {31'd0, bus.mem_we}, 32'd1);
          chk("wr_addr", {16'd0, bus.mem_addr}, {16'd0, exp_addr[pend]});
          chk("wr_data", {24'd0, bus.mem_wdata}, {24'd0, exp_data[pend]});
        end else begin
          chk("no_wr", {31'd0, bus.mem_we}, 32'd0);
        end
      end
    end
    pend = (chk_en && bus.in_valid && bus.in_ready && !rst) ? cur_idx : -1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 8'h00;
    bus.cpu_we    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    exp_pc = 16'h0200;
    chk_en = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_run", {31'd0, cpu_run}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_pc", {16'd0, pc_reset}, 32'h0200);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);

    // T1: single block then END.
    strm = '{8'h01, 8'h00, 8'h02, 8'h03, 8'h00, 8'hA9, 8'h05, 8'hEA, 8'h02, 8'h00, 8'h02};
    add_cs(8'h00);
    model_parse();
    chk("model_t1_addr5", {16'd0, exp_addr[5]}, 32'h0200);
    chk("model_t1_addr7", {16'd0, exp_addr[7]}, 32'h0202);
    chk("model_t1_pc", {16'd0, exp_pc}, 32'h0200);
    wr_seen = 0;
    send_stream(-1, 0);
    finish_check("t1");
    chk("t1_writes", wr_seen, 32'd3);
    chk("t1_pc_lit", {16'd0, pc_reset}, 32'h0200);
    chk("t1_done_lit", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    bus.cpu_addr  = 16'h0123;
    bus.cpu_wdata = 8'h77;
    bus.cpu_we    = 1'b1;
    @(negedge clk);
    chk("t1_cpu_addr", {16'd0, bus.mem_addr}, 32'h0123);
    chk("t1_cpu_we", {31'd0, bus.mem_we}, 32'd1);
    @(posedge clk); #1;
    bus.cpu_we = 1'b0;

    // T2: two blocks, the second of zero length.
    strm = '{8'h01, 8'h00, 8'h03, 8'h02, 8'h00, 8'h11, 8'h22,
             8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h03};
    add_cs(8'h00);
    model_parse();
    chk("model_t2_pc", {16'd0, exp_pc}, 32'h0300);
    wr_seen = 0;
    send_stream(-1, 0);
    finish_check("t2");
    chk("t2_writes", wr_seen, 32'd2);

    // T3: block crossing the end of memory, then recovery.
    strm = '{8'h01, 8'hFF, 8'h03, 8'h02, 8'h00};
    model_parse();
    chk("model_t3_stop", stop_n, 32'd5);
    wr_seen = 0;
    send_stream(-1, 0);
    finish_check("t3");
    chk("t3_writes", wr_seen, 32'd0);
    chk("t3_err_lit", {31'd0, err}, 32'd1);
    strm = '{8'h01, 8'h00, 8'h02, 8'h03, 8'h00, 8'hA9, 8'h05, 8'hEA, 8'h02, 8'h00, 8'h02};
    add_cs(8'h00);
    model_parse();
    wr_seen = 0;
    send_stream(-1, 0);
    finish_check("t3r");
    chk("t3r_writes", wr_seen, 32'd3);

    // T4: bad opcode; CPU writes blocked while held in reset.
    strm = '{8'h7F};
    model_parse();
    chk("model_t4_stop", stop_n, 32'd1);
    send_stream(-1, 0);
    finish_check("t4");
    @(posedge clk); #1;
    bus.cpu_addr  = 16'h0040;
    bus.cpu_wdata = 8'h99;
    bus.cpu_we    = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_cpu_blocked", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk); #1;
    bus.cpu_we = 1'b0;

    // T5: 16-byte block with random gaps; rst arrives with the 9th data byte.
    strm = '{8'h01, 8'h00, 8'h01, 8'h10, 8'h00};
    for (int k = 0; k < 16; k++) strm.push_back(8'(8'h30 + k));
    strm.push_back(8'h02);
    strm.push_back(8'h00);
    strm.push_back(8'h02);
    add_cs(8'h00);
    model_parse();
    chk("model_t5_addr12", {16'd0, exp_addr[12]}, 32'h0107);
    wr_seen = 0;
    send_stream(13, 2);
    exp_pc = 16'h0200;
    @(negedge clk);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_run", {31'd0, cpu_run}, 32'd0);
    chk("t5_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_pc", {16'd0, pc_reset}, {16'd0, exp_pc});
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t5_writes", wr_seen, 32'd8);

`ifdef CHECKSUM_EN
    // T6: good checksum, then the same stream with checksum + 1.
    strm = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h42, 8'h02, 8'h00, 8'h03};
    add_cs(8'h00);
    model_parse();
    send_stream(-1, 0);
    finish_check("t6a");
    chk("t6a_pc_lit", {16'd0, pc_reset}, 32'h0300);
    strm = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h42, 8'h02, 8'h00, 8'h03};
    add_cs(8'h01);
    model_parse();
    send_stream(-1, 0);
    finish_check("t6b");
    chk("t6b_err_lit", {31'd0, err}, 32'd1);
    chk("t6b_pc_lit", {16'd0, pc_reset}, 32'h0300);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
